// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping an external 64x8 dual-port RAM (A write, B read).
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module ram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [DATA_W-1:0] ram_din_a,
   output logic              ram_we_a,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic              ram_we_b,
   input  logic [DATA_W-1:0] ram_dout_b
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              empty_reg, full_reg, rd_valid_reg;
   logic              push_acc, pop_acc;

   // Gating by the registered flags means a pop on empty never reads through a same-cycle push.
   assign push_acc = wr_en && !full_reg;
   assign pop_acc  = rd_en && !empty_reg;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push_acc) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop_acc)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      case ({push_acc, pop_acc})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         empty_reg    <= 1'b1;
         full_reg     <= 1'b0;
         rd_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         empty_reg    <= (count_next == '0);
         full_reg     <= (count_next == DEPTH);
         rd_valid_reg <= pop_acc;
      end
   end

   assign ram_we_a   = push_acc;
   assign ram_addr_a = wr_ptr_reg;
   assign ram_din_a  = wr_data;
   assign ram_addr_b = rd_ptr_reg;
   assign ram_we_b   = 1'b0;

   // The RAM registers port B itself, so its output lines up with rd_valid.
   assign rd_data  = ram_dout_b;
   assign rd_valid = rd_valid_reg;
   assign count    = count_reg;
   assign empty    = empty_reg;
   assign full     = full_reg;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_reg, underflow_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_en && full_reg)  overflow_reg  <= 1'b1;
         if (rd_en && empty_reg) underflow_reg <= 1'b1;
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the team's 64x8 dual-port RAM as its storage: port A is write-only, port B is read-only.
- Sits between a producer (write side) and a consumer (read side) and turns raw RAM ports into push/pop with full/empty flags and occupancy count.
- The RAM stays a separate instance; this block owns pointers, flags and read-data timing only.

Parameters:
- DATA_W, 8, data width; must match RAM word width.
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  push request.
- wr_data  input  DATA_W  push data.
- full  output  1  FIFO holds 2**ADDR_W entries.
- rd_en  input  1  pop request.
- rd_data  output  DATA_W  popped data; valid when rd_valid=1.
- rd_valid  output  1  rd_data qualifier, one cycle after accepted pop.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  current occupancy, 0..64.
- ram_addr_a  output  ADDR_W  to RAM address_a.
- ram_din_a  output  DATA_W  to RAM input_data_a.
- ram_we_a  output  1  to RAM we_a.
- ram_addr_b  output  ADDR_W  to RAM address_b.
- ram_we_b  output  1  to RAM we_b; constant 0.
- ram_dout_b  input  DATA_W  from RAM output_data_b.

Behaviour:
- Reset (rst_n=0, async):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0.
  - RAM contents are not cleared.
- Push accepted iff wr_en && !full. Combinational outputs: ram_we_a=accept, ram_addr_a=wr_ptr, ram_din_a=wr_data. On accept, wr_ptr increments with natural wrap 63->0.
- Pop accepted iff rd_en && !empty. Combinational output: ram_addr_b=rd_ptr.
  - RAM registers the word at the next edge.
  - rd_valid is registered: it is 1 in the cycle after an accepted pop, else 0.
  - rd_data = ram_dout_b, passed through.
  - rd_ptr increments on accept with wrap 63->0.
- Read latency: 1 clock from accepted pop to rd_valid/rd_data. Back-to-back pops give one word per cycle.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- empty = (count==0), full = (count==64); both registered, derived from next count.
- Simultaneous push+pop:
  - when empty: only the push is accepted (no read-through); count becomes 1.
  - when full: only the pop is accepted; count becomes 63.
  - otherwise: both are accepted; count is unchanged.
- Refused push or pop: no pointer, count or RAM change; ram_we_a=0.
- Read and write never target the same address in one cycle: pop of an unwritten slot is impossible because of the empty gating.
- Reset asserted mid-stream drops all contents; an in-flight rd_valid is cleared immediately.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow (1 bit) and underflow (1 bit).
  - Both are sticky, set on wr_en&&full and rd_en&&empty respectively.
  - Both are cleared only by reset; reset value 0.
- Not defined: ports absent; refused requests are silently ignored.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, rd_valid=0, ram_we_a=0.
- Push 0x11,0x22,0x33 on consecutive cycles, then pop 3 back-to-back -> rd_valid high 3 cycles, rd_data 0x11,0x22,0x33 in order, count returns to 0, empty=1.
- Push 64 words 0x00..0x3F -> full=1 and count=64 after the 64th. Extra push 0xAA is refused: ram_we_a=0, count stays 64, overflow=1 if FIFO_ERR_FLAGS_EN. Pop all 64 -> data 0x00..0x3F, 0xAA never appears.
- Fill to 10, then 100 cycles of simultaneous push/pop with incrementing data -> count stays 10; pointers wrap past 63 with data order preserved.
- Empty FIFO, wr_en=rd_en=1 with 0x5A -> push accepted, no rd_valid next cycle, count=1. Next cycle pop -> rd_data=0x5A with rd_valid.
- Fill to 5, assert rst_n=0 for 1 cycle during a pop -> rd_valid drops at once, count=0, empty=1. A subsequent push/pop of 0x77 returns 0x77.
